wb_ctrl_pipe: RTL and testbench

Parametrised write-back controller for the RISC-V core: the register-file write port and the last pipeline stage. It takes each retiring instruction from execute, decodes from the opcode whether and what to write, selects the result source, and aligns and sign-extends load data. It waits for load data from data memory through a small FSM. It also blocks writes to x0, killed (flushed) instructions and misaligned loads.

---
 rtl/wb_ctrl_pipe.sv | 199 +++++++++++++++++++
 tb/tb_wb_ctrl_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl_pipe.sv
// Write-back controller: decodes retiring instructions, drives the register-file
// write port, and waits for load data through a two-state FSM.
module wb_ctrl_pipe #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned RF_AW         = 5,
    parameter bit          ZERO_SUPPRESS = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instr,
    input  logic [XLEN-1:0]    i_alu,
    input  logic [XLEN-1:0]    i_pc,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic [XLEN-1:0]    i_mem_rdata,
    input  logic               i_mem_rvalid,
    output logic               o_reg_wr_en,
    output logic [RF_AW-1:0]   o_reg_wr_addr,
    output logic [XLEN-1:0]    o_reg_wr_data,
    output logic               o_misaligned,
    output logic               o_busy
);

    localparam int unsigned OFFW = $clog2(XLEN / 8);
    localparam int unsigned SHW  = OFFW + 3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               wr_en_q, wr_en_d;
    logic [RF_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]    wr_data_q, wr_data_d;
    logic               mis_q, mis_d;

    // Pending-load context captured at acceptance
    logic [RF_AW-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]         ld_f3_q, ld_f3_d;
    logic [OFFW-1:0]    ld_off_q, ld_off_d;
    logic               ld_bad_q, ld_bad_d;
    logic               ld_wr_q, ld_wr_d;

    logic [6:0]         opcode;
    logic [RF_AW-1:0]   rd;
    logic [2:0]         funct3;
    logic [OFFW-1:0]    offset;
    logic               accept;
    logic               live;
    logic               rd_ok;
    logic               ld_bad_c;
    logic [SHW-1:0]     shamt;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    ld_data;
    logic               unused_instr;

    assign opcode       = i_instr[6:0];
    assign rd           = RF_AW'(i_instr[11:7]);
    assign funct3       = i_instr[14:12];
    assign offset       = i_alu[OFFW-1:0];
    assign unused_instr = ^i_instr[31:15];

    assign o_ready = (state_q == ST_IDLE) & ~i_halt;
    assign accept  = i_valid & o_ready;
    assign live    = accept & ~i_flush;
    assign rd_ok   = !(ZERO_SUPPRESS && (i_instr[11:7] == 5'd0));

    // Alignment / legality check of the load being accepted
    always_comb begin
        ld_bad_c = 1'b0;
        case (funct3)
            3'b000, 3'b100: ld_bad_c = 1'b0;
            3'b001, 3'b101: ld_bad_c = offset[0];
            3'b010:         ld_bad_c = (offset[1:0] != 2'b00);
            3'b110:         ld_bad_c = (XLEN == 32) ? 1'b1 : (offset[1:0] != 2'b00);
            3'b011:         ld_bad_c = (XLEN == 32) ? 1'b1 : (offset != '0);
            default:        ld_bad_c = 1'b1;
        endcase
    end

    // Align the returned memory word and sign/zero-extend by access size
    always_comb begin
        shamt   = {ld_off_q, 3'b000};
        shifted = i_mem_rdata >> shamt;
        ld_data = shifted;
        case (ld_f3_q)
            3'b000:  ld_data = XLEN'($signed(shifted[7:0]));
            3'b100:  ld_data = XLEN'(shifted[7:0]);
            3'b001:  ld_data = XLEN'($signed(shifted[15:0]));
            3'b101:  ld_data = XLEN'(shifted[15:0]);
            3'b010:  ld_data = XLEN'($signed(shifted[31:0]));
            3'b110:  ld_data = XLEN'(shifted[31:0]);
            default: ld_data = shifted;
        endcase
    end

    // Next-state, write-port and load-context decode
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mis_d     = 1'b0;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        ld_off_d  = ld_off_q;
        ld_bad_d  = ld_bad_q;
        ld_wr_d   = ld_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (live) begin
                    case (opcode)
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                            if (rd_ok) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = rd;
                                wr_data_d = i_alu;
                            end
                        end
                        OPC_JAL, OPC_JALR: begin
                            if (rd_ok) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = rd;
                                wr_data_d = i_pc + XLEN'(4);
                            end
                        end
                        OPC_LOAD: begin
                            state_d  = ST_WAIT_MEM;
                            ld_rd_d  = rd;
                            ld_f3_d  = funct3;
                            ld_off_d = offset;
                            ld_bad_d = ld_bad_c;
                            ld_wr_d  = rd_ok;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (i_mem_rvalid) begin
                    state_d = ST_IDLE;
                    if (ld_bad_q) begin
                        mis_d = 1'b1;
                    end else if (ld_wr_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ld_rd_q;
                        wr_data_d = ld_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            mis_q     <= 1'b0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_off_q  <= '0;
            ld_bad_q  <= 1'b0;
            ld_wr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            mis_q     <= mis_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            ld_off_q  <= ld_off_d;
            ld_bad_q  <= ld_bad_d;
            ld_wr_q   <= ld_wr_d;
        end
    end

    assign o_reg_wr_en   = wr_en_q;
    assign o_reg_wr_addr = wr_addr_q;
    assign o_reg_wr_data = wr_data_q;
    assign o_misaligned  = mis_q;
    assign o_busy        = (state_q == ST_WAIT_MEM);

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Scoreboard bench for wb_ctrl_pipe (XLEN=32, ZERO_SUPPRESS=1).
module tb_wb_ctrl_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RF_AW = 5;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic               i_clk;
    logic               i_rst;
    logic               i_valid;
    logic               o_ready;
    logic [31:0]        i_instr;
    logic [XLEN-1:0]    i_alu;
    logic [XLEN-1:0]    i_pc;
    logic               i_halt;
    logic               i_flush;
    logic [XLEN-1:0]    i_mem_rdata;
    logic               i_mem_rvalid;
    logic               o_reg_wr_en;
    logic [RF_AW-1:0]   o_reg_wr_addr;
    logic [XLEN-1:0]    o_reg_wr_data;
    logic               o_misaligned;
    logic               o_busy;

    wb_ctrl_pipe #(.XLEN(XLEN), .RF_AW(RF_AW), .ZERO_SUPPRESS(1'b1)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_instr      (i_instr),
        .i_alu        (i_alu),
        .i_pc         (i_pc),
        .i_halt       (i_halt),
        .i_flush      (i_flush),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_rvalid (i_mem_rvalid),
        .o_reg_wr_en  (o_reg_wr_en),
        .o_reg_wr_addr(o_reg_wr_addr),
        .o_reg_wr_data(o_reg_wr_data),
        .o_misaligned (o_misaligned),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_mis[$];
    wr_t mon_e;
    int  mon_c;
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every write / misaligned pulse must match the head of its queue
    always @(negedge i_clk) begin
        if (o_reg_wr_en) begin
            if (exp_wr.size() == 0) begin
                check("wr_spurious", 64'(o_reg_wr_en), 64'd0);
            end else begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", 64'(o_reg_wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(o_reg_wr_data), 64'(mon_e.data));
                check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
            mon_e = exp_wr.pop_front();
            check("wr_missing", 64'(o_reg_wr_en), 64'd1);
        end
        if (o_misaligned) begin
            if (exp_mis.size() == 0) begin
                check("mis_spurious", 64'(o_misaligned), 64'd0);
            end else begin
                mon_c = exp_mis.pop_front();
                check("mis_cycle", 64'(cyc), 64'(mon_c));
            end
        end else if (exp_mis.size() > 0 && exp_mis[0] <= cyc) begin
            mon_c = exp_mis.pop_front();
            check("mis_missing", 64'(o_misaligned), 64'd1);
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
        return {17'd0, f3, rd, op};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] pc,
                         input logic flush, input logic exp_en, input logic [31:0] exp_data);
        check("ready_issue", 64'(o_ready), 64'd1);
        i_valid = 1'b1;
        i_instr = instr;
        i_alu   = alu;
        i_pc    = pc;
        i_flush = flush;
        if (exp_en) exp_wr.push_back('{addr: instr[11:7], data: exp_data, cyc: cyc + 1});
        step();
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] rdata, input int delay, input logic exp_bad,
                           input logic exp_en, input logic [31:0] exp_data, input logic noise);
        check("ready_ld_issue", 64'(o_ready), 64'd1);
        i_valid = 1'b1;
        i_instr = mk(OP_LOAD, rd, f3);
        i_alu   = addr;
        step();
        i_valid = 1'b0;
        check("busy_after_accept", 64'(o_busy), 64'd1);
        check("ready_after_accept", 64'(o_ready), 64'd0);
        for (int k = 0; k < delay; k++) begin
            // Present a flushed ADD while waiting: neither it nor the flush may matter
            i_valid = noise;
            i_flush = noise;
            i_instr = mk(OP_OP, 5'd9, 3'b000);
            i_alu   = 32'h5555_5555;
            step();
            check("ready_wait", 64'(o_ready), 64'd0);
            check("busy_wait", 64'(o_busy), 64'd1);
        end
        i_valid      = 1'b0;
        i_flush      = 1'b0;
        i_mem_rdata  = rdata;
        i_mem_rvalid = 1'b1;
        if (exp_en)  exp_wr.push_back('{addr: rd, data: exp_data, cyc: cyc + 1});
        if (exp_bad) exp_mis.push_back(cyc + 1);
        step();
        i_mem_rvalid = 1'b0;
        check("ready_after_load", 64'(o_ready), 64'd1);
        check("busy_after_load", 64'(o_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_instr      = '0;
        i_alu        = '0;
        i_pc         = '0;
        i_halt       = 1'b0;
        i_flush      = 1'b0;
        i_mem_rdata  = '0;
        i_mem_rvalid = 1'b0;
        step();
        step();
        check("rst_wr_en", 64'(o_reg_wr_en), 64'd0);
        check("rst_wr_addr", 64'(o_reg_wr_addr), 64'd0);
        check("rst_wr_data", 64'(o_reg_wr_data), 64'd0);
        check("rst_mis", 64'(o_misaligned), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        i_rst = 1'b0;
        step();

        // Back-to-back ADD, SW, BEQ: only ADD writes
        issue(mk(OP_OP, 5'd5, 3'b000), 32'h0000_1234, 32'h0, 1'b0, 1'b1, 32'h0000_1234);
        issue(mk(OP_STORE, 5'd6, 3'b010), 32'h0000_2000, 32'h0, 1'b0, 1'b0, 32'h0);
        issue(mk(OP_BRANCH, 5'd7, 3'b000), 32'h0000_0001, 32'h0, 1'b0, 1'b0, 32'h0);
        // JAL link value and wrap, ADDI to x0 suppressed
        issue(mk(OP_JAL, 5'd1, 3'b000), 32'h0, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0104);
        issue(mk(OP_JAL, 5'd1, 3'b000), 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0000);
        issue(mk(OP_IMM, 5'd0, 3'b000), 32'hABCD_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        // Flushed ADD dropped
        issue(mk(OP_OP, 5'd4, 3'b000), 32'hDEAD_0000, 32'h0, 1'b1, 1'b0, 32'h0);
        issue(mk(OP_IMM, 5'd31, 3'b000), 32'h7777_0001, 32'h0, 1'b0, 1'b1, 32'h7777_0001);
        step();

        // Loads: extraction, latency, misalignment
        do_load(3'b000, 5'd7,  32'h0000_1003, 32'h80FF_0000, 3, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0);
        do_load(3'b100, 5'd8,  32'h0000_1003, 32'h80FF_0000, 0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
        do_load(3'b001, 5'd9,  32'h0000_1002, 32'h80FF_0000, 1, 1'b0, 1'b1, 32'hFFFF_80FF, 1'b0);
        do_load(3'b101, 5'd10, 32'h0000_1002, 32'h80FF_0000, 0, 1'b0, 1'b1, 32'h0000_80FF, 1'b0);
        do_load(3'b010, 5'd11, 32'h0000_1000, 32'hDEAD_BEEF, 2, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        do_load(3'b000, 5'd14, 32'h0000_1001, 32'h0000_7F00, 0, 1'b0, 1'b1, 32'h0000_007F, 1'b0);
        do_load(3'b010, 5'd12, 32'h0000_1002, 32'h1111_2222, 1, 1'b1, 1'b0, 32'h0, 1'b0);
        do_load(3'b011, 5'd13, 32'h0000_1000, 32'h1111_2222, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        do_load(3'b001, 5'd0,  32'h0000_1001, 32'h1111_2222, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        do_load(3'b000, 5'd0,  32'h0000_1000, 32'h1111_2222, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        // Write port holds last value between pulses
        step();
        check("hold_addr", 64'(o_reg_wr_addr), 64'd14);
        check("hold_data", 64'(o_reg_wr_data), 64'h7F);

        // rvalid while idle is ignored
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hCAFE_F00D;
        step();
        i_mem_rvalid = 1'b0;
        check("idle_rvalid_busy", 64'(o_busy), 64'd0);

        // Halt blocks acceptance
        i_halt  = 1'b1;
        i_valid = 1'b1;
        i_instr = mk(OP_OP, 5'd3, 3'b000);
        i_alu   = 32'h3333_3333;
        #1;
        check("halt_ready", 64'(o_ready), 64'd0);
        step();
        step();
        check("halt_ready2", 64'(o_ready), 64'd0);
        i_valid = 1'b0;
        i_halt  = 1'b0;
        #1;
        check("unhalt_ready", 64'(o_ready), 64'd1);

        // Reset in WAIT_MEM abandons the load
        i_valid = 1'b1;
        i_instr = mk(OP_LOAD, 5'd15, 3'b010);
        i_alu   = 32'h0000_2000;
        step();
        i_valid = 1'b0;
        check("pre_rst_busy", 64'(o_busy), 64'd1);
        i_rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(o_busy), 64'd0);
        check("rst_mid_ready", 64'(o_ready), 64'd1);
        step();
        i_rst        = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h1234_5678;
        step();
        i_mem_rvalid = 1'b0;
        check("post_rst_busy", 64'(o_busy), 64'd0);
        check("post_rst_ready", 64'(o_ready), 64'd1);

        // Normal traffic still works after the abandoned load
        issue(mk(OP_OP, 5'd2, 3'b000), 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);
        step();
        step();
        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("mis_queue_empty", 64'(exp_mis.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
